kbd_ctrl: RTL
=============

KBD_CTRL -- requirements
Module: kbd_ctrl

Interface
REQ-001 CNT_W, 8, width of key-press counter.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 code  input  8  PS/2 scancode byte from receiver.
REQ-005 code_valid  input  1  code valid this cycle; accepted only when code_ready=1.
REQ-006 code_ready  output  1  block can accept a scancode byte.
REQ-007 xlat_code  output  8  registered scancode driven to the combinational scancode-to-ASCII translator.
REQ-008 xlat_ascii  input  8  translator output for xlat_code, combinational, 8'h00 = unmapped.
REQ-009 key_valid  output  1  key_ascii/key_code hold a new key event.
REQ-010 key_ready  input  1  consumer accepts event when key_valid=1 and key_ready=1.
REQ-011 key_ascii  output  8  ASCII of the pressed key.
REQ-012 key_code  output  8  make code of the pressed key.
REQ-013 key_down  output  1  a non-modifier key is currently held.
REQ-014 key_count  output  CNT_W  count of emitted key events.

Function
REQ-015 FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen), LOOKUP, OUT.
REQ-016 code_ready = 1 in IDLE, BRK, EXT and EXT_BRK, and 0 in LOOKUP and OUT.
REQ-017 IDLE: 8'hF0 -> BRK; 8'hE0 -> EXT; any other byte is a make code.
REQ-018 EXT: F0 -> EXT_BRK; any other byte is an extended make and is discarded -> IDLE.
REQ-019 EXT_BRK: any byte is discarded -> IDLE.
REQ-020 BRK: next byte is a break code; if it equals held code, key_down <= 0; -> IDLE.
REQ-021 Make code equal to held code while key_down=1 is typematic repeat: discarded, -> IDLE.
REQ-022 Other make: xlat_code <= code, held code <= code, key_down <= 1, -> LOOKUP.
REQ-023 LOOKUP (1 cycle): if xlat_ascii = 8'h00, no event is emitted -> IDLE; else key_ascii <= xlat_ascii, key_code <= xlat_code, key_valid <= 1 -> OUT.
REQ-024 Latency: make accepted in cycle N -> key_valid=1 in cycle N+2.
REQ-025 OUT: key_valid, key_ascii and key_code stay stable until key_ready=1; on the handshake cycle key_valid <= 0 and the FSM goes to IDLE.
REQ-026 key_count increments by 1 on each handshake and wraps from all-ones to 0.
REQ-027 Modifier codes 8'h12 and 8'h59 never change key_down or the held code and never emit events.
REQ-028 code_valid while code_ready=0 is ignored; the upstream receiver holds or drops the byte.

Reset
REQ-029 rst=1 forces, without waiting for clk: state IDLE; key_valid, key_down, key_ascii, key_code, xlat_code and key_count all 0; held code 8'h00; shift flag 0.
REQ-030 rst asserted mid-sequence (BRK/EXT/LOOKUP/OUT) abandons the pending event; no event is emitted after rst is released.

Configuration
REQ-031 Macro KBD_SHIFT_EN.
REQ-032 Defined: the shift flag is set by make 12/59 and cleared by break F0 12 / F0 59; when xlat_ascii is in 8'h41-8'h5A and shift=0, key_ascii = xlat_ascii + 8'h20; otherwise key_ascii = xlat_ascii.
REQ-033 Undefined: there is no shift flag; key_ascii = xlat_ascii unmodified; 12/59 are still treated as modifiers per REQ-027.

Verification
REQ-034 Bytes 1C then F0 1C, key_ready=1 -> one event, key_code=1C, key_ascii=41 (macro off) or 61 (macro on), key_count=1, key_down ends 0.
REQ-035 Bytes 1C, 1C, 1C (repeat), then F0 1C -> exactly one event; key_count=1.
REQ-036 Macro on: bytes 12, 1C, F0 1C, F0 12, 1C -> events with key_ascii 41 then 61.
REQ-037 key_ready=0 for 10 cycles after 16 -> key_valid, key_ascii=31 and key_code held stable; code_ready=0 throughout; one event on release.
REQ-038 Bytes E0 75, then E0 F0 75, then 0E (unmapped) -> no events; key_count unchanged.
REQ-039 rst pulse in LOOKUP after make 45 -> all outputs 0 asynchronously; no event for 45 after release.

Source files
------------

// File: rtl/kbd_if.sv
// kbd_if: scancode input, translator loop-back and key event output bundle.
// The slave modport is the controller view; the master modport is the
// receiver / translator / consumer side that drives it.
interface kbd_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       code;
    logic             code_valid;
    logic             code_ready;
    logic [7:0]       xlat_code;
    logic [7:0]       xlat_ascii;
    logic             key_valid;
    logic             key_ready;
    logic [7:0]       key_ascii;
    logic [7:0]       key_code;
    logic             key_down;
    logic [CNT_W-1:0] key_count;

    modport slave (
        input  code, code_valid, xlat_ascii, key_ready,
        output code_ready, xlat_code, key_valid, key_ascii, key_code,
               key_down, key_count
    );

    modport master (
        output code, code_valid, xlat_ascii, key_ready,
        input  code_ready, xlat_code, key_valid, key_ascii, key_code,
               key_down, key_count
    );
endinterface

// File: rtl/kbd_ctrl.sv
// kbd_ctrl: PS/2 scancode decoder. Filters break/extended/typematic bytes,
// looks up ASCII through an external combinational translator and emits
// one valid/ready key event per new make code.
// Optional feature: define KBD_SHIFT_EN to track shift (12/59) and fold
// unshifted upper-case letters to lower case.
module kbd_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic  clk,
    input  logic  rst,
    kbd_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_LOOKUP, S_OUT
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [7:0]       r_xlat_code;
    logic [7:0]       r_held;
    logic             r_key_down;
    logic             r_key_valid;
    logic [7:0]       r_key_ascii;
    logic [7:0]       r_key_code;
    logic [CNT_W-1:0] r_key_count;

    logic             w_ready;
    logic             w_accept;
    logic             w_is_mod;
    logic             w_make;
    logic             w_brk_byte;
    logic             w_emit;
    logic             w_hs;
    logic [7:0]       w_ascii_out;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_BRK) ||
                      (r_state == S_EXT)  || (r_state == S_EXT_BRK);
    assign w_accept = bus.code_valid && w_ready;
    assign w_is_mod = (bus.code == 8'h12) || (bus.code == 8'h59);
    assign w_emit   = (r_state == S_LOOKUP) && (bus.xlat_ascii != 8'h00);
    assign w_hs     = (r_state == S_OUT) && bus.key_ready;

`ifdef KBD_SHIFT_EN
    logic r_shift;

    // Shift flag: set by a modifier make, cleared by a modifier break.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_shift <= 1'b0;
        else if (w_accept && w_is_mod && r_state == S_IDLE)
            r_shift <= 1'b1;
        else if (w_accept && w_is_mod && r_state == S_BRK)
            r_shift <= 1'b0;
    end

    // Unshifted letters are presented in lower case.
    assign w_ascii_out = (!r_shift && bus.xlat_ascii >= 8'h41 &&
                          bus.xlat_ascii <= 8'h5A) ?
                         bus.xlat_ascii + 8'h20 : bus.xlat_ascii;
`else
    assign w_ascii_out = bus.xlat_ascii;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode plus make/break qualifiers for the datapath.
    always_comb begin
        w_next     = r_state;
        w_make     = 1'b0;
        w_brk_byte = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (bus.code == 8'hF0)
                    w_next = S_BRK;
                else if (bus.code == 8'hE0)
                    w_next = S_EXT;
                else if (w_is_mod || (r_key_down && bus.code == r_held))
                    w_next = S_IDLE;          // modifier or typematic repeat
                else begin
                    w_make = 1'b1;
                    w_next = S_LOOKUP;
                end
            end
            S_BRK: if (w_accept) begin
                w_brk_byte = 1'b1;
                w_next     = S_IDLE;
            end
            S_EXT: if (w_accept)
                w_next = (bus.code == 8'hF0) ? S_EXT_BRK : S_IDLE;
            S_EXT_BRK: if (w_accept)
                w_next = S_IDLE;
            S_LOOKUP:
                w_next = (bus.xlat_ascii == 8'h00) ? S_IDLE : S_OUT;
            S_OUT: if (bus.key_ready)
                w_next = S_IDLE;
            default:
                w_next = S_IDLE;
        endcase
    end

    // Held key tracking, translator code, event registers and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xlat_code <= 8'h00;
            r_held      <= 8'h00;
            r_key_down  <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_ascii <= 8'h00;
            r_key_code  <= 8'h00;
            r_key_count <= '0;
        end else begin
            if (w_make) begin
                r_xlat_code <= bus.code;
                r_held      <= bus.code;
                r_key_down  <= 1'b1;
            end
            if (w_brk_byte && !w_is_mod && bus.code == r_held)
                r_key_down <= 1'b0;
            if (w_emit) begin
                r_key_ascii <= w_ascii_out;
                r_key_code  <= r_xlat_code;
                r_key_valid <= 1'b1;
            end
            if (w_hs) begin
                r_key_valid <= 1'b0;
                r_key_count <= r_key_count + 1'b1;
            end
        end
    end

    assign bus.code_ready = w_ready;
    assign bus.xlat_code  = r_xlat_code;
    assign bus.key_valid  = r_key_valid;
    assign bus.key_ascii  = r_key_ascii;
    assign bus.key_code   = r_key_code;
    assign bus.key_down   = r_key_down;
    assign bus.key_count  = r_key_count;

endmodule
